fifo_drain_ser: RTL and testbench

FIFO_DRAIN_SER -- requirements
Module: fifo_drain_ser

---
 rtl/fifo_drain_ser_pkg.sv | 20 ++
 rtl/fifo_drain_ser.sv | 110 +++++++++++
 tb/tb_fifo_drain_ser.sv | 252 +++++++++++++++++++++++++
 3 files changed

// File: rtl/fifo_drain_ser_pkg.sv
// Shared definitions for the FIFO drain serializer: FSM encoding, default header
// byte and the bytes-per-word calculation.
package fifo_drain_ser_pkg;

  typedef enum logic [2:0] {
    IDLE,
    POP,
    LOAD,
    SYNC,
    DATA,
    CSUM
  } state_t;

  localparam logic [7:0] SYNC_BYTE_DEFAULT = 8'hAA;

  function automatic int unsigned num_bytes(input int unsigned buf_length);
    return (buf_length + 1) / 8;
  endfunction

endpackage

// File: rtl/fifo_drain_ser.sv
// Pops one word at a time from a FIFO and sends it as a byte packet:
// sync byte, data bytes MSB-first, then XOR checksum of the data bytes.
module fifo_drain_ser
  import fifo_drain_ser_pkg::*;
#(
  parameter int unsigned BUF_LENGTH = 63,
  parameter logic [7:0]  SYNC_BYTE  = SYNC_BYTE_DEFAULT
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  buf_empty,
  input  logic [BUF_LENGTH:0]   buf_out,
  output logic                  rd_en,
  output logic [7:0]            tx_data,
  output logic                  tx_valid,
  input  logic                  tx_ready,
  output logic                  busy,
  output logic [15:0]           word_count
);

  localparam int unsigned NB    = num_bytes(BUF_LENGTH);
  localparam int unsigned IDX_W = (NB > 1) ? $clog2(NB) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NB - 1);

  state_t              state;
  logic [BUF_LENGTH:0] shreg;
  logic [IDX_W-1:0]    idx;
  logic [7:0]          csum;

  // Outputs are registered alongside the state: each transition loads the
  // values the next state presents, so tx_data holds while a byte is stalled.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      rd_en      <= 1'b0;
      tx_valid   <= 1'b0;
      tx_data    <= '0;
      busy       <= 1'b0;
      word_count <= '0;
      idx        <= '0;
      csum       <= '0;
      shreg      <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (!buf_empty) begin
            state <= POP;
            rd_en <= 1'b1;
            busy  <= 1'b1;
          end
        end
        POP: begin
          state <= LOAD;
          rd_en <= 1'b0;
        end
        LOAD: begin
          shreg    <= buf_out;
          csum     <= '0;
          idx      <= '0;
          state    <= SYNC;
          tx_valid <= 1'b1;
          tx_data  <= SYNC_BYTE;
        end
        SYNC: begin
          if (tx_ready) begin
            state   <= DATA;
            tx_data <= shreg[BUF_LENGTH -: 8];
            shreg   <= shreg << 8;
          end
        end
        DATA: begin
          if (tx_ready) begin
            csum <= csum ^ tx_data;
            if (idx == LAST_IDX) begin
              state   <= CSUM;
              tx_data <= csum ^ tx_data;
            end else begin
              idx     <= idx + IDX_W'(1);
              tx_data <= shreg[BUF_LENGTH -: 8];
              shreg   <= shreg << 8;
            end
          end
        end
        CSUM: begin
          if (tx_ready) begin
            word_count <= word_count + 16'd1;
            tx_valid   <= 1'b0;
            tx_data    <= '0;
            idx        <= '0;
            if (!buf_empty) begin
              state <= POP;
              rd_en <= 1'b1;
            end else begin
              state <= IDLE;
              busy  <= 1'b0;
            end
          end
        end
        default: begin
          state    <= IDLE;
          rd_en    <= 1'b0;
          tx_valid <= 1'b0;
          tx_data  <= '0;
          busy     <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fifo_drain_ser.sv
// Directed self-checking bench for fifo_drain_ser with a small FIFO model
// and a byte monitor on the transmit side.
module tb_fifo_drain_ser;

  logic        clk = 1'b0;
  logic        rst;
  logic        buf_empty;
  logic [63:0] buf_out;
  logic        rd_en;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready;
  logic        busy;
  logic [15:0] word_count;

  fifo_drain_ser #(.BUF_LENGTH(63), .SYNC_BYTE(8'hAA)) dut (
    .clk        (clk),
    .rst        (rst),
    .buf_empty  (buf_empty),
    .buf_out    (buf_out),
    .rd_en      (rd_en),
    .tx_data    (tx_data),
    .tx_valid   (tx_valid),
    .tx_ready   (tx_ready),
    .busy       (busy),
    .word_count (word_count)
  );

  always #5 clk = ~clk;

  // FIFO model: read data appears the cycle after rd_en is sampled
  logic [63:0] mem [0:15];
  int wr_ptr = 0;
  int rd_ptr = 0;
  assign buf_empty = (rd_ptr == wr_ptr);

  always @(posedge clk) begin
    if (rd_en && (rd_ptr != wr_ptr)) begin
      buf_out <= mem[rd_ptr % 16];
      rd_ptr  <= rd_ptr + 1;
    end
  end

  task automatic push(input logic [63:0] w);
    mem[wr_ptr % 16] = w;
    wr_ptr = wr_ptr + 1;
  endtask

  int passed = 0;
  int total  = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp)
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    else
      passed++;
  endtask

  logic [7:0] log_b [$];
  int         log_c [$];
  logic [7:0] exp_b [$];
  int  cyc        = 0;
  int  rd_pulses  = 0;
  int  idle_bad   = 0;
  int  stall_bad  = 0;
  int  stall_seen = 0;
  bit  saw_valid  = 0;
  bit  saw_busy   = 0;
  bit  stall_prev = 0;
  logic [7:0] stall_data;

  always @(negedge clk) begin
    cyc++;
    if (!rst) begin
      if (tx_valid && tx_ready) begin
        log_b.push_back(tx_data);
        log_c.push_back(cyc);
      end
      if (rd_en) rd_pulses++;
      if (!tx_valid && tx_data != 8'h00) idle_bad++;
      if (tx_valid) saw_valid = 1;
      if (busy) saw_busy = 1;
      if (stall_prev && tx_valid) begin
        stall_seen++;
        if (tx_data != stall_data) stall_bad++;
      end
    end
    stall_prev = !rst && tx_valid && !tx_ready;
    stall_data = tx_data;
  end

  task automatic clear_logs();
    log_b.delete();
    log_c.delete();
    exp_b.delete();
    rd_pulses = 0;
    idle_bad  = 0;
    stall_bad = 0;
    saw_valid = 0;
    saw_busy  = 0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    clear_logs();
  endtask

  task automatic expect_word(input logic [63:0] w, input logic [7:0] cs);
    exp_b.push_back(8'hAA);
    for (int i = 7; i >= 0; i--) exp_b.push_back(w[i*8 +: 8]);
    exp_b.push_back(cs);
  endtask

  task automatic run_packets(input int budget, input bit toggle);
    bit seen = 0;
    int n = 0;
    forever begin
      @(posedge clk);
      #1;
      if (toggle) tx_ready = ~tx_ready;
      if (busy) seen = 1;
      n++;
      if (seen && !busy && buf_empty) break;
      if (n >= budget) begin
        check("run_timeout_cycles", n, 0);
        break;
      end
    end
  endtask

  task automatic compare_bytes(input string tag);
    check({tag, "_nbytes"}, log_b.size(), exp_b.size());
    for (int i = 0; i < exp_b.size() && i < log_b.size(); i++)
      check($sformatf("%s_byte%0d", tag, i), log_b[i], exp_b[i]);
  endtask

  initial begin
    rst      = 1'b1;
    tx_ready = 1'b0;
    do_reset();

    check("rst_rd_en",    rd_en,      0);
    check("rst_tx_valid", tx_valid,   0);
    check("rst_tx_data",  tx_data,    0);
    check("rst_busy",     busy,       0);
    check("rst_wcount",   word_count, 0);

    // single word, always ready
    tx_ready = 1'b1;
    push(64'h0123_4567_89AB_CDEF);
    expect_word(64'h0123_4567_89AB_CDEF, 8'h00);
    run_packets(60, 0);
    compare_bytes("w1");
    check("w1_rd_pulses", rd_pulses, 1);
    check("w1_wcount", word_count, 1);
    check("w1_idle_zero", idle_bad, 0);

    // backpressure toggling every cycle
    do_reset();
    tx_ready = 1'b1;
    stall_seen = 0;
    push(64'h0000_0000_0000_00FF);
    expect_word(64'h0000_0000_0000_00FF, 8'hFF);
    run_packets(120, 1);
    compare_bytes("bp");
    check("bp_stall_stable", stall_bad, 0);
    check("bp_stalls_seen", stall_seen > 5, 1);
    check("bp_wcount", word_count, 1);
    check("bp_idle_zero", idle_bad, 0);

    // three back-to-back words
    do_reset();
    tx_ready = 1'b1;
    push(64'h0102_0304_0506_0708);
    push(64'hFFFF_FFFF_FFFF_FFFF);
    push(64'h8000_0000_0000_0001);
    expect_word(64'h0102_0304_0506_0708, 8'h08);
    expect_word(64'hFFFF_FFFF_FFFF_FFFF, 8'h00);
    expect_word(64'h8000_0000_0000_0001, 8'h81);
    run_packets(150, 0);
    compare_bytes("b2b");
    if (log_c.size() >= 21) begin
      check("b2b_gap1", log_c[10] - log_c[9], 3);
      check("b2b_gap2", log_c[20] - log_c[19], 3);
    end
    check("b2b_rd_pulses", rd_pulses, 3);
    check("b2b_wcount", word_count, 3);

    // reset in the middle of DATA byte 3; the popped word is dropped
    do_reset();
    tx_ready = 1'b1;
    push(64'h1122_3344_5566_7788);
    push(64'h0123_4567_89AB_CDEF);
    begin
      int n = 0;
      forever begin
        @(negedge clk);
        n++;
        if (tx_valid && tx_data == 8'h44) break;
        if (n >= 60) begin
          check("midrst_timeout_cycles", n, 0);
          break;
        end
      end
    end
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    check("midrst_tx_valid", tx_valid, 0);
    check("midrst_busy", busy, 0);
    check("midrst_wcount", word_count, 0);
    check("midrst_tx_data", tx_data, 0);
    clear_logs();
    expect_word(64'h0123_4567_89AB_CDEF, 8'h00);
    run_packets(60, 0);
    compare_bytes("midrst");
    check("midrst_rd_pulses", rd_pulses, 1);
    check("midrst_wcount_after", word_count, 1);

    // permanently empty FIFO
    do_reset();
    tx_ready = 1'b1;
    repeat (20) @(posedge clk);
    #1;
    check("empty_rd_pulses", rd_pulses, 0);
    check("empty_saw_valid", saw_valid, 0);
    check("empty_saw_busy", saw_busy, 0);

    // counter wrap, starting from a preset value
    do_reset();
    tx_ready = 1'b1;
    force dut.word_count = 16'hFFFE;
    @(posedge clk);
    #1 release dut.word_count;
    @(posedge clk);
    #1;
    check("wrap_preset", word_count, 16'hFFFE);
    push(64'h0000_0000_0000_0001);
    run_packets(60, 0);
    check("wrap_ffff", word_count, 16'hFFFF);
    push(64'h0000_0000_0000_0002);
    run_packets(60, 0);
    check("wrap_zero", word_count, 16'h0000);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
